// File: rtl/pwm_led.sv
// LED brightness controller: two active-low buttons step a duty level that drives one shared PWM waveform.
// Optional AUTO_REPEAT_EN macro: a held button generates repeat steps.
module pwm_led #(
    parameter int LED_COUNT = 6,
    parameter int DEB_WIDTH = 21,
    parameter int PWM_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic                 down,
    output logic [LED_COUNT-1:0] led
);

    localparam int                 LEVEL_MAX_I = 2 ** PWM_WIDTH;
    localparam logic [PWM_WIDTH:0] LEVEL_MAX   = LEVEL_MAX_I[PWM_WIDTH:0];
    localparam logic [PWM_WIDTH:0] LEVEL_RST   = LEVEL_MAX >> 1;

    logic [1:0]           btn_raw;
    logic [1:0]           pulse;
    logic [PWM_WIDTH:0]   level;
    logic [PWM_WIDTH-1:0] cnt;

    // Index 0 is up, index 1 is down.
    assign btn_raw = {down, up};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic                 sync1;
        logic                 sync2;
        logic                 deb;
        logic                 deb_d;
        logic                 press;
        logic                 step;
        logic                 pulse_q;
        logic [DEB_WIDTH-1:0] deb_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1   <= 1'b1;
                sync2   <= 1'b1;
                deb     <= 1'b1;
                deb_d   <= 1'b1;
                deb_cnt <= '0;
            end else begin
                sync1 <= btn_raw[i];
                sync2 <= sync1;
                deb_d <= deb;
                if (sync2 == deb) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == '1) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        assign press = deb_d & ~deb;

`ifdef AUTO_REPEAT_EN
        localparam int RPT_W = DEB_WIDTH + 3;

        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt;

        // Down-counter reaches zero one clock before the repeat pulse is registered,
        // so loading N-1 yields a pulse N clocks after the previous one.
        assign rpt = ~deb & ~deb_d & (rpt_cnt == '0);

        always_ff @(posedge clk) begin
            if (rst || deb) begin
                rpt_cnt <= '0;
            end else if (press) begin
                rpt_cnt <= {3'b111, {DEB_WIDTH{1'b1}}};
            end else if (rpt) begin
                rpt_cnt <= {3'b000, {DEB_WIDTH{1'b1}}};
            end else begin
                rpt_cnt <= rpt_cnt - 1'b1;
            end
        end

        assign step = press | rpt;
`else
        assign step = press;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= step;
            end
        end

        assign pulse[i] = pulse_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= LEVEL_RST;
        end else if (pulse[0] && !pulse[1] && level != LEVEL_MAX) begin
            level <= level + 1'b1;
        end else if (pulse[1] && !pulse[0] && level != '0) begin
            level <= level - 1'b1;
        end
    end

    // Extra compare bit lets level == 2^PWM_WIDTH mean always on.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            led <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            led <= {LED_COUNT{({1'b0, cnt} < level)}};
        end
    end

endmodule

// File: tb/tb_pwm_led.sv
// Scoreboarded bench for pwm_led: stimulus queues expected duty counts, a monitor measures led over a window.
module tb_pwm_led;

    localparam int LED_COUNT = 6;

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b1;
    logic                 up   = 1'b1;
    logic                 down = 1'b1;
    logic [LED_COUNT-1:0] led;

    pwm_led #(
        .LED_COUNT(LED_COUNT),
        .DEB_WIDTH(2),
        .PWM_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (up),
        .down (down),
        .led  (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    window;
        int    exp_high;
    } meas_t;

    meas_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_issued = 0;
    int    n_done   = 0;

    // Any window of whole PWM periods at a steady level holds exactly level*periods high clocks.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                meas_t m;
                int    highs;
                bit    split;
                m     = q.pop_front();
                highs = 0;
                split = 1'b0;
                for (int i = 0; i < m.window; i++) begin
                    if (i > 0) @(negedge clk);
                    if (led == '1) highs++;
                    else if (led != '0) split = 1'b1;
                end
                n_checks++;
                if (highs == m.exp_high && !split) n_pass++;
                else $display("FAIL %s: led high %0d of %0d clocks (bits split=%0d), expected %0d",
                              m.name, highs, m.window, split, m.exp_high);
                n_done++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic measure(input string name, input int window, input int exp_high);
        meas_t m;
        m.name     = name;
        m.window   = window;
        m.exp_high = exp_high;
        q.push_back(m);
        n_issued++;
        for (int t = 0; t < window + 20 && n_done < n_issued; t++) @(posedge clk);
        #1;
        if (n_done < n_issued) begin
            n_checks++;
            $display("FAIL %s: monitor timed out, completed %0d of %0d measurements", name, n_done, n_issued);
            n_done = n_issued;
        end
    endtask

    task automatic press(input bit pu, input bit pd, input int hold);
        up   = ~pu;
        down = ~pd;
        tick(hold);
        up   = 1'b1;
        down = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        measure("reset_led_off", 2, 0);
        rst = 1'b0;
        tick(4);
        measure("reset_level8", 16, 8);
        measure("reset_level8_two_periods", 32, 16);

        press(1'b1, 1'b0, 20);
        measure("hold20_single_step", 16, 9);

        press(1'b1, 1'b0, 2);
        measure("glitch_ignored", 16, 9);

        press(1'b1, 1'b1, 10);
        measure("both_cancel", 16, 9);

        do_reset();
        measure("reset_restores_8", 16, 8);

        repeat (10) press(1'b1, 1'b0, 10);
        measure("saturate_high", 32, 32);

        repeat (20) press(1'b0, 1'b1, 10);
        measure("saturate_low", 32, 0);

        press(1'b1, 1'b0, 10);
        measure("level1", 16, 1);
        press(1'b1, 1'b0, 10);
        measure("level2", 16, 2);

        // Reset lands after debounce accepted the press but before the step: press discarded.
        up = 1'b0;
        tick(6);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        up = 1'b1;
        tick(12);
        measure("rst_midpress_no_step", 16, 8);

        // Button still held across reset release is debounced again, then accepted once.
        up = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        up = 1'b1;
        tick(12);
        measure("held_through_reset_redebounced", 16, 9);

`ifdef AUTO_REPEAT_EN
        do_reset();
        press(1'b0, 1'b1, 20);
        measure("hold20_before_repeat", 16, 7);
        do_reset();
        press(1'b0, 1'b1, 100);
        measure("hold100_repeat_to_zero", 32, 0);
`else
        do_reset();
        press(1'b0, 1'b1, 100);
        measure("hold100_single_step", 16, 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
